// File: rtl/fft_frame_loader.sv
// Windows a real sample stream with a Hann LUT and loads it, bit-reversed and pre-scaled, into the FFT RAM.
// Accept-to-write latency is 2 cycles; after N samples the loader drains, then holds fft_start until fft_done.
module fft_frame_loader #(
    parameter int width = 16,
    parameter int N_2   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic [width-1:0]     sample,
    output logic                 sample_ready,
    output logic [N_2-1:0]       win_idx,
    input  logic [width-1:0]     win_coef,
    output logic                 ram_we,
    output logic [N_2-1:0]       ram_adr,
    output logic [2*width-1:0]   ram_wd,
    output logic                 fft_start,
    input  logic                 fft_done,
    output logic                 busy
);

    localparam logic [N_2-1:0] CNT_LAST = {N_2{1'b1}};

    typedef enum logic [1:0] {LOAD, DRAIN, RUN} state_t;

    state_t               state, state_nxt;
    logic [N_2-1:0]       cnt, cnt_nxt;
    logic                 dcnt, dcnt_nxt;
    logic                 start_nxt;
    logic                 accept;
    logic [N_2-1:0]       adr_rev;

    logic                 s1_vld;
    logic [width-1:0]     s1_sample;
    logic [N_2-1:0]       s1_adr;

    logic signed [2*width-1:0] prod;
    logic signed [2*width-1:0] prod_sh;
    logic [2*width-1:0]        wd_nxt;

    assign sample_ready = (state == LOAD);
    assign busy         = (state != LOAD);
    assign win_idx      = cnt;
    assign accept       = sample_valid & sample_ready;

    always_comb begin
        adr_rev = '0;
        for (int i = 0; i < N_2; i++) begin
            adr_rev[i] = cnt[N_2-1-i];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dcnt_nxt  = dcnt;
        start_nxt = 1'b0;
        case (state)
            LOAD: begin
                dcnt_nxt = 1'b0;
                if (accept) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Two idle cycles let the last sample clear both pipeline stages.
                if (dcnt) begin
                    state_nxt = RUN;
                    start_nxt = 1'b1;
                    dcnt_nxt  = 1'b0;
                end else begin
                    dcnt_nxt = 1'b1;
                end
            end
            RUN: begin
                start_nxt = 1'b1;
                if (fft_done) begin
                    state_nxt = LOAD;
                    start_nxt = 1'b0;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            dcnt      <= 1'b0;
            fft_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dcnt      <= dcnt_nxt;
            fft_start <= start_nxt;
        end
    end

    // Signed sample times zero-extended coefficient; one arithmetic shift does the
    // upper-half select and the bit-growth headroom, truncating toward -inf.
    assign prod    = $signed({{width{s1_sample[width-1]}}, s1_sample}) *
                     $signed({{width{1'b0}}, win_coef});
    assign prod_sh = prod >>> (width + N_2);
    assign wd_nxt  = prod_sh << width;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s1_sample <= '0;
            s1_adr    <= '0;
            ram_we    <= 1'b0;
            ram_adr   <= '0;
            ram_wd    <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_sample <= sample;
                s1_adr    <= adr_rev;
            end
            ram_we <= s1_vld;
            if (s1_vld) begin
                ram_adr <= s1_adr;
                ram_wd  <= wd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with a registered Hann-LUT model and a write scoreboard.
module tb_fft_frame_loader;
    localparam int W  = 16;
    localparam int NB = 5;
    localparam int N  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_valid;
    logic [W-1:0]      sample;
    logic              sample_ready;
    logic [NB-1:0]     win_idx;
    logic [W-1:0]      win_coef;
    logic              ram_we;
    logic [NB-1:0]     ram_adr;
    logic [2*W-1:0]    ram_wd;
    logic              fft_start;
    logic              fft_done;
    logic              busy;

    fft_frame_loader #(.width(W), .N_2(NB)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .sample_ready(sample_ready), .win_idx(win_idx), .win_coef(win_coef),
        .ram_we(ram_we), .ram_adr(ram_adr), .ram_wd(ram_wd),
        .fft_start(fft_start), .fft_done(fft_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] coef_tab [N];
    logic [W-1:0] sample_tab [N];

    initial win_coef = '0;
    always @(posedge clk) win_coef <= coef_tab[win_idx];

    typedef struct {
        logic [NB-1:0]  adr;
        logic [2*W-1:0] wd;
        int             cyc;
    } exp_t;

    exp_t           sb[$];
    int             cyc = 0;
    int             mcnt = 0;
    int             wr_cnt = 0;
    logic [N-1:0]   seen = '0;
    logic [2*W-1:0] wd_at [N];
    int             wr_adr[$];
    int             checks = 0;
    int             failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] brev(input int k);
        logic [NB-1:0] r;
        for (int i = 0; i < NB; i++) r[NB-1-i] = k[i];
        return r;
    endfunction

    function automatic logic [2*W-1:0] model_wd(input logic [W-1:0] s, input logic [W-1:0] c);
        longint p;
        longint q;
        p = longint'($signed(s)) * longint'({48'b0, c});
        q = p >>> (W + NB);
        return {q[W-1:0], {W{1'b0}}};
    endfunction

    // Monitor pops before the accept push, both on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            mcnt = 0;
        end else begin
            if (ram_we) begin
                if (sb.size() == 0) begin
                    chk("spurious_we", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ram_adr", ram_adr, e.adr);
                    chk("ram_wd", ram_wd, e.wd);
                    chk("write_cycle", cyc, e.cyc);
                end
                wr_cnt++;
                seen[ram_adr] = 1'b1;
                wd_at[ram_adr] = ram_wd;
                wr_adr.push_back(int'(ram_adr));
            end
            if (sample_valid && sample_ready) begin
                chk("win_idx", win_idx, mcnt);
                sb.push_back('{brev(mcnt), model_wd(sample, coef_tab[mcnt]), cyc + 2});
                mcnt = (mcnt + 1) % N;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        seen = '0;
        wr_adr.delete();
    endtask

    task automatic run_frame(input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(1) == 1; g++) begin
                    sample_valid = 1'b0;
                    step();
                end
            end
            sample_valid = 1'b1;
            sample = sample_tab[k];
            step();
        end
        sample_valid = 1'b0;
    endtask

    // Called just after the edge that accepted the last sample.
    task automatic wait_start();
        chk("ready_after_last", sample_ready, 0);
        chk("busy_drain", busy, 1);
        chk("start_drain0", fft_start, 0);
        step();
        chk("start_drain1", fft_start, 0);
        step();
        chk("start_run", fft_start, 1);
        chk("write_count", wr_cnt, N);
        chk("addr_cover", seen, {N{1'b1}});
    endtask

    task automatic release_fft();
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        chk("start_drop", fft_start, 0);
        chk("ready_rearm", sample_ready, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", sample_ready, 1);
        chk("rst_we", ram_we, 0);
        chk("rst_adr", ram_adr, 0);
        chk("rst_wd", ram_wd, 0);
        chk("rst_start", fft_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", win_idx, 0);
    endtask

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0;
        sample = '0;
        fft_done = 1'b0;
        for (int k = 0; k < N; k++) begin
            coef_tab[k] = 16'hFFFF;
            sample_tab[k] = W'(k);
        end
        #12;
        chk_reset_vals();
        step();
        reset = 1'b0;
        step();

        // Frame 1: ramp samples, full-scale coefficients, no gaps.
        clear_log();
        run_frame(1'b0);
        wait_start();
        chk("first_adr0", wr_adr[0], 0);
        chk("first_adr1", wr_adr[1], 16);
        chk("first_adr2", wr_adr[2], 8);

        for (int i = 0; i < 100; i++) begin
            chk("hold_start", fft_start, 1);
            chk("hold_ready", sample_ready, 0);
            step();
        end
        release_fft();
        chk("rearm_idx", win_idx, 0);
        fft_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_ignored_busy", busy, 0);
            chk("done_ignored_start", fft_start, 0);
        end
        fft_done = 1'b0;

        // Frame 2: arithmetic corner cases at indices 0, 1, 2.
        for (int k = 0; k < N; k++) begin
            coef_tab[k] = W'($urandom);
            sample_tab[k] = W'($urandom);
        end
        sample_tab[0] = 16'h7FFF; coef_tab[0] = 16'h8000;
        sample_tab[1] = 16'h8000; coef_tab[1] = 16'hFFFF;
        sample_tab[2] = 16'h1234; coef_tab[2] = 16'h0000;
        clear_log();
        run_frame(1'b0);
        wait_start();
        chk("arith_pos", wd_at[0], 32'h01FF0000);
        chk("arith_neg", wd_at[16], 32'hFC000000);
        chk("arith_zero", wd_at[8], 32'h00000000);
        release_fft();

        // Frame 3: random valid gaps.
        for (int k = 0; k < N; k++) begin
            coef_tab[k] = W'($urandom);
            sample_tab[k] = W'($urandom);
        end
        clear_log();
        run_frame(1'b1);
        wait_start();
        release_fft();

        // Reset after 10 accepts, with writes still in flight.
        clear_log();
        for (int k = 0; k < 10; k++) begin
            sample_valid = 1'b1;
            sample = sample_tab[k];
            step();
        end
        sample_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_vals();
        sb.delete();
        step();
        step();
        reset = 1'b0;
        step();
        chk("post_reset_idle", ram_we, 0);

        clear_log();
        run_frame(1'b0);
        wait_start();
        chk("restart_adr0", wr_adr[0], 0);

        // Reset while the FFT runs.
        step();
        reset = 1'b1;
        #1;
        chk_reset_vals();
        step();
        reset = 1'b0;
        step();
        chk("post_run_reset_ready", sample_ready, 1);
        chk("post_run_reset_start", fft_start, 0);
        chk("post_run_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
